bf_branch_unit: RTL
===================

Name: bf_branch_unit

Overview:
- Loop-control stage directly downstream of the instruction decoder in the bfX core.
- Receives decoded '[' (0x5B) and ']' (0x5D) instructions with the current data-cell zero flag.
- When a branch is taken, stalls the core and scans program memory for the matching bracket using a nesting-depth counter, then issues a one-cycle PC redirect.
- Branches that are not taken fall through with no stall.

Parameters:
ADDR_W, 16, program address width; must match pc.
DEPTH_W, 8, nesting-depth counter width.
STACK_DEPTH, 8, loop-stack entries; used only with LOOP_STACK_EN.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
ix_valid  input  1  decoded instruction is valid this cycle.
ix_branch  input  1  decoder branch-class flag.
ix_byte  input  8  raw instruction byte.
ix_pc  input  ADDR_W  address of the current instruction.
cell_zero  input  1  current data cell equals 0.
fetch_req  output  1  program-memory read request during a scan.
fetch_addr  output  ADDR_W  scan read address.
fetch_data  input  8  read data; returned one cycle after fetch_req.
stall  output  1  hold core pc and fetch.
redirect  output  1  one-cycle pulse; core loads redirect_pc.
redirect_pc  output  ADDR_W  new pc.
err_unmatched  output  1  sticky fault: no matching bracket or depth overflow.

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state=IDLE; depth=0; scan_addr=0; in-flight fetch discarded.
  - All outputs 0; err_unmatched cleared; stack emptied.
- States: IDLE, SCAN_FWD, SCAN_BWD, REDIRECT, FAULT.
- Trigger in IDLE requires ix_valid & ix_branch:
  - '[' & cell_zero -> SCAN_FWD; depth=1; scan_addr=ix_pc+1.
  - ']' & !cell_zero -> SCAN_BWD; depth=1; scan_addr=ix_pc-1.
  - Any other byte or flag combination: no action, stall=0.
- stall = trigger | (state != IDLE). It is combinational, so it is high in the trigger cycle.
- SCAN, one byte per cycle:
  - fetch_req=1 and fetch_addr=scan_addr each cycle.
  - scan_addr increments (FWD) or decrements (BWD) each cycle.
  - Returned data is evaluated the following cycle.
- Depth update:
  - FWD: '[' -> depth+1; ']' -> depth-1.
  - BWD: ']' -> depth+1; '[' -> depth-1.
  - All other bytes are ignored.
- Match: depth reaches 0 on the byte from address A.
  - Latch redirect_pc=A+1 and go to REDIRECT.
  - The one over-fetched byte in flight is discarded.
- REDIRECT: lasts one cycle; redirect=1, stall=1; next state IDLE.
- Timing for a match at distance d from the trigger at cycle T:
  - fetch issued at T+d; evaluated at T+d+1.
  - redirect at T+d+2; IDLE at T+d+3.
- Boundaries, each entering FAULT:
  - FWD scan would issue address 2^ADDR_W-1+1 (wrap).
  - BWD scan would issue address below 0.
  - depth would exceed 2^DEPTH_W-1.
- FAULT: err_unmatched=1, stall=1 and fetch_req=0 until reset.
- While state != IDLE, ix_* inputs are ignored.
- redirect_pc holds its last value when redirect=0.

Optional Feature:
LOOP_STACK_EN
- Defined: hardware loop stack of STACK_DEPTH ADDR_W-bit entries.
  - '[' not taken (cell nonzero): push ix_pc.
  - ']' not taken (cell zero): pop; ignored if empty.
  - ']' taken with stack non-empty: no scan. State goes to REDIRECT at T+1 with redirect_pc=top+1; no pop; stall high for 2 cycles.
  - ']' taken with stack empty: normal backward scan.
  - Push when full: flush the whole stack to empty, then push. This is safe because the empty-stack fallback is the scan.
  - '[' taken (forward scan): no stack change.
- Undefined: no stack logic; every taken ']' scans backward.

Test Plan:
- Program "[]" at pc 10, 11; '[' at 10 with cell_zero=1 -> fetch_addr 11 at T+1; redirect=1 with redirect_pc=12 at T+3; stall high T..T+3.
- Program "[[-]+]" at 20..25; '[' at 20, cell_zero=1 -> depth 1,2,2,1,1,0; redirect_pc=26 at T+7.
- ']' at 25 of the same program, cell_zero=0, macro undefined -> backward scan; match at 20; redirect_pc=21 at T+7.
- ']' at 40, cell_zero=0 with no '[' below (addresses 0..39 hold '+') -> FAULT; err_unmatched=1; stall held; rst_n pulse low -> all outputs 0.
- Reset asserted at T+3 of a forward scan -> state IDLE immediately; no redirect pulse afterwards; the next valid trigger is handled normally.
- LOOP_STACK_EN defined:
  - '[' at 50 not taken pushes 50; then ']' at 60 taken -> redirect_pc=51 at T+1 with fetch_req never asserted.
  - ']' at 60 not taken -> stack empty afterwards.

Source files
------------

// File: rtl/bf_branch_unit.sv
// bf_branch_unit: resolves taken '[' / ']' branches by scanning program memory for the matching bracket.
// Optional LOOP_STACK_EN (`ifdef) adds a loop-address stack that short-circuits taken ']' branches.
module bf_branch_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_W     = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ix_valid,
  input  logic              ix_branch,
  input  logic [7:0]        ix_byte,
  input  logic [ADDR_W-1:0] ix_pc,
  input  logic              cell_zero,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [7:0]        fetch_data,
  output logic              stall,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              err_unmatched
);

  localparam logic [7:0]         OPEN_B    = 8'h5B;
  localparam logic [7:0]         CLOSE_B   = 8'h5D;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  if (STACK_DEPTH < 1) begin : g_cfg_check
    $error("STACK_DEPTH must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_FWD,
    S_SCAN_BWD,
    S_REDIRECT,
    S_FAULT
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   scan_addr_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic                pend_q;
  logic                oob_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic [ADDR_W-1:0]   redirect_pc_q;

  logic                in_idle;
  logic                br_ok;
  logic                ix_open;
  logic                ix_close;
  logic                trig_fwd;
  logic                trig_bwd;
  logic                scan_fwd;
  logic                scanning;
  logic                byte_inc;
  logic                byte_dec;
  logic                match;
  logic                depth_ovf;
  logic [DEPTH_W-1:0]  depth_d;
  logic [ADDR_W-1:0]   scan_addr_d;
  logic                oob_d;
  logic                stack_hit;
  logic [ADDR_W-1:0]   stack_top;

  assign in_idle  = (state_q == S_IDLE);
  assign br_ok    = in_idle & ix_valid & ix_branch;
  assign ix_open  = (ix_byte == OPEN_B);
  assign ix_close = (ix_byte == CLOSE_B);
  assign trig_fwd = br_ok & ix_open & cell_zero;
  assign trig_bwd = br_ok & ix_close & ~cell_zero;
  assign scan_fwd = (state_q == S_SCAN_FWD);
  assign scanning = scan_fwd | (state_q == S_SCAN_BWD);

  // Nesting direction flips with scan direction.
  assign byte_inc = scan_fwd ? (fetch_data == OPEN_B)  : (fetch_data == CLOSE_B);
  assign byte_dec = scan_fwd ? (fetch_data == CLOSE_B) : (fetch_data == OPEN_B);

  assign scan_addr_d = scan_fwd ? (scan_addr_q + ADDR_W'(1)) : (scan_addr_q - ADDR_W'(1));
  assign oob_d       = scan_fwd ? (&scan_addr_q) : (~|scan_addr_q);

  // Evaluate the byte fetched in the previous cycle.
  always_comb begin
    depth_d   = depth_q;
    depth_ovf = 1'b0;
    match     = 1'b0;
    if (pend_q) begin
      if (byte_inc) begin
        depth_ovf = (depth_q == DEPTH_MAX);
        depth_d   = depth_q + DEPTH_W'(1);
      end else if (byte_dec) begin
        match   = (depth_q == DEPTH_W'(1));
        depth_d = depth_q - DEPTH_W'(1);
      end
    end
  end

`ifdef LOOP_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic              stk_push;
  logic              stk_pop;
  logic              stk_full;

  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stk_push  = br_ok & ix_open & ~cell_zero;
  assign stk_pop   = br_ok & ix_close & cell_zero & (sp_q != '0);
  assign stack_hit = trig_bwd & (sp_q != '0);
  assign stack_top = stack_q[IDX_W'(sp_q - SP_W'(1))];

  // Overflow flushes to empty; an empty stack falls back to the scan, so no loop is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (stk_push) begin
      if (stk_full) begin
        stack_q[0] <= ix_pc;
        sp_q       <= SP_W'(1);
      end else begin
        stack_q[IDX_W'(sp_q)] <= ix_pc;
        sp_q                  <= sp_q + SP_W'(1);
      end
    end else if (stk_pop) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end
`else
  assign stack_hit = 1'b0;
  assign stack_top = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      scan_addr_q   <= '0;
      pend_addr_q   <= '0;
      pend_q        <= 1'b0;
      oob_q         <= 1'b0;
      depth_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pend_q <= 1'b0;
          if (stack_hit) begin
            redirect_pc_q <= stack_top + ADDR_W'(1);
            state_q       <= S_REDIRECT;
          end else if (trig_fwd) begin
            state_q     <= S_SCAN_FWD;
            depth_q     <= DEPTH_W'(1);
            scan_addr_q <= ix_pc + ADDR_W'(1);
            oob_q       <= &ix_pc;
          end else if (trig_bwd) begin
            state_q     <= S_SCAN_BWD;
            depth_q     <= DEPTH_W'(1);
            scan_addr_q <= ix_pc - ADDR_W'(1);
            oob_q       <= ~|ix_pc;
          end
        end
        S_SCAN_FWD, S_SCAN_BWD: begin
          if (match) begin
            redirect_pc_q <= pend_addr_q + ADDR_W'(1);
            pend_q        <= 1'b0;
            state_q       <= S_REDIRECT;
          end else if (depth_ovf || oob_q) begin
            pend_q  <= 1'b0;
            state_q <= S_FAULT;
          end else begin
            depth_q     <= depth_d;
            pend_q      <= 1'b1;
            pend_addr_q <= scan_addr_q;
            scan_addr_q <= scan_addr_d;
            oob_q       <= oob_d;
          end
        end
        S_REDIRECT: state_q <= S_IDLE;
        S_FAULT:    state_q <= S_FAULT;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_req     = scanning & ~oob_q;
  assign fetch_addr    = fetch_req ? scan_addr_q : '0;
  assign stall         = trig_fwd | trig_bwd | ~in_idle;
  assign redirect      = (state_q == S_REDIRECT);
  assign redirect_pc   = redirect_pc_q;
  assign err_unmatched = (state_q == S_FAULT);

endmodule
